// File: rtl/bicubic_phase_sched.sv
// Bicubic horizontal phase scheduler: issues xBlend/src_col per output pixel.
// Optional Q16 phase accumulator when BICUBIC_SCHED_FINE_PHASE_EN is defined.
module bicubic_phase_sched #(
   parameter int LAT   = 7,
   parameter int COL_W = 12
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [COL_W-1:0] line_width_out,
   input  logic [8:0]       phase_inc,
   input  logic [8:0]       bi_a_cfg,
`ifdef BICUBIC_SCHED_FINE_PHASE_EN
   input  logic [7:0]       phase_inc_frac,
`endif
   input  logic             hold,
   output logic             busy,
   output logic             done,
   output logic [8:0]       coeffOne,
   output logic [8:0]       coeffHalf,
   output logic [8:0]       bi_a,
   output logic [8:0]       xBlend,
   output logic             iss_valid,
   output logic [COL_W-1:0] src_col,
   output logic             w_valid,
   output logic [COL_W-1:0] w_src_col,
   output logic             w_last
);

`ifdef BICUBIC_SCHED_FINE_PHASE_EN
   localparam int AW = 16;
`else
   localparam int AW = 8;
`endif

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN} state_t;

   state_t             state_q, state_d;
   logic [COL_W-1:0]   lw_q, cnt_q, col_q;
   logic [8:0]         inc_q, bia_q;
`ifdef BICUBIC_SCHED_FINE_PHASE_EN
   logic [7:0]         incf_q;
`endif
   logic [AW-1:0]      acc_q;
   logic [AW+1:0]      inc_ext, sum;
   logic [3:0]         dcnt_q;
   logic               done_q, done_d;
   logic               issue, last;
   logic [LAT-1:0]     dv_q, dl_q;
   logic [COL_W-1:0]   dc_q [LAT];

`ifdef BICUBIC_SCHED_FINE_PHASE_EN
   assign inc_ext = {1'b0, inc_q, incf_q};
`else
   assign inc_ext = {1'b0, inc_q};
`endif
   assign sum = {2'b00, acc_q} + inc_ext;

   // Next-state, issue and done decode
   always_comb begin
      state_d = state_q;
      done_d  = 1'b0;
      issue   = 1'b0;
      last    = 1'b0;
      unique case (state_q)
         S_IDLE: begin
            if (start) begin
               if (line_width_out == '0) done_d  = 1'b1;
               else                      state_d = S_RUN;
            end
         end
         S_RUN: begin
            if (!hold) begin
               issue = 1'b1;
               last  = (cnt_q == lw_q - COL_W'(1));
               if (last) state_d = S_DRAIN;
            end
         end
         S_DRAIN: begin
            if (dcnt_q == 4'(LAT - 1)) begin
               state_d = S_IDLE;
               done_d  = 1'b1;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   // State register and done pulse
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         done_q  <= done_d;
      end
   end

   // Config latch, phase accumulator, column and pixel counters
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         lw_q   <= '0;
         inc_q  <= '0;
         bia_q  <= '0;
`ifdef BICUBIC_SCHED_FINE_PHASE_EN
         incf_q <= '0;
`endif
         acc_q  <= '0;
         col_q  <= '0;
         cnt_q  <= '0;
         dcnt_q <= '0;
      end else begin
         if (state_q == S_IDLE && start) begin
            lw_q   <= line_width_out;
            inc_q  <= phase_inc;
            bia_q  <= bi_a_cfg;
`ifdef BICUBIC_SCHED_FINE_PHASE_EN
            incf_q <= phase_inc_frac;
`endif
            acc_q  <= '0;
            col_q  <= '0;
            cnt_q  <= '0;
         end else if (issue) begin
            acc_q <= sum[AW-1:0];
            col_q <= col_q + {{(COL_W-2){1'b0}}, sum[AW+1:AW]};
            cnt_q <= cnt_q + COL_W'(1);
         end
         if (state_q == S_DRAIN) dcnt_q <= dcnt_q + 4'd1;
         else                    dcnt_q <= '0;
      end
   end

   // Free-running delay line matching the weight datapath latency
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         dv_q <= '0;
         dl_q <= '0;
         for (int i = 0; i < LAT; i++) dc_q[i] <= '0;
      end else begin
         dv_q[0] <= issue;
         dl_q[0] <= issue & last;
         dc_q[0] <= col_q;
         for (int i = 1; i < LAT; i++) begin
            dv_q[i] <= dv_q[i-1];
            dl_q[i] <= dl_q[i-1];
            dc_q[i] <= dc_q[i-1];
         end
      end
   end

   assign busy      = (state_q != S_IDLE);
   assign done      = done_q;
   assign coeffOne  = 9'd256;
   assign coeffHalf = 9'd128;
   assign bi_a      = bia_q;
   assign xBlend    = {1'b0, acc_q[AW-1:AW-8]};
   assign iss_valid = issue;
   assign src_col   = col_q;
   assign w_valid   = dv_q[LAT-1];
   assign w_src_col = dc_q[LAT-1];
   assign w_last    = dl_q[LAT-1];

endmodule

// File: tb/tb_bicubic_phase_sched.sv
// Directed cycle-table bench for bicubic_phase_sched.
// Delayed outputs are checked against a history of expected issues.
module tb_bicubic_phase_sched;

   localparam int LAT   = 7;
   localparam int COL_W = 12;
   localparam int MAXR  = 160;

   logic             clk = 1'b0;
   logic             rst_n;
   logic             start;
   logic [COL_W-1:0] line_width_out;
   logic [8:0]       phase_inc;
   logic [8:0]       bi_a_cfg;
   logic             hold;
   logic             busy, done;
   logic [8:0]       coeffOne, coeffHalf, bi_a, xBlend;
   logic             iss_valid, w_valid, w_last;
   logic [COL_W-1:0] src_col, w_src_col;
`ifdef BICUBIC_SCHED_FINE_PHASE_EN
   logic [7:0]       phase_inc_frac = 8'd0;
`endif

   always #5 clk = ~clk;

   bicubic_phase_sched #(.LAT(LAT), .COL_W(COL_W)) dut (
      .clk(clk), .rst_n(rst_n), .start(start),
      .line_width_out(line_width_out), .phase_inc(phase_inc),
      .bi_a_cfg(bi_a_cfg),
`ifdef BICUBIC_SCHED_FINE_PHASE_EN
      .phase_inc_frac(phase_inc_frac),
`endif
      .hold(hold), .busy(busy), .done(done),
      .coeffOne(coeffOne), .coeffHalf(coeffHalf), .bi_a(bi_a),
      .xBlend(xBlend), .iss_valid(iss_valid), .src_col(src_col),
      .w_valid(w_valid), .w_src_col(w_src_col), .w_last(w_last)
   );

   typedef struct {
      logic             st, hd, rs;
      logic [COL_W-1:0] lw;
      logic [8:0]       pi, bia;
      logic             e_iss;
      logic [8:0]       e_xb;
      logic [COL_W-1:0] e_col;
      logic             e_last, e_done, e_busy;
      logic [8:0]       e_bia;
   } vec_t;

   vec_t vecs [MAXR];
   int   nrow = 0;
   int   n_tests = 0;
   int   n_fail = 0;

   logic [8:0]       prev_xb  = 9'd0;
   logic [COL_W-1:0] prev_col = '0;
   logic [8:0]       prev_bia = 9'd0;

   logic             h_iss  [MAXR];
   logic             h_last [MAXR];
   logic [COL_W-1:0] h_col  [MAXR];

   function automatic void add_row(
      input logic st, input logic hd, input logic rs,
      input logic [COL_W-1:0] lw, input logic [8:0] pi,
      input logic [8:0] bia, input logic e_iss,
      input logic [8:0] e_xb, input logic [COL_W-1:0] e_col,
      input logic e_last, input logic e_done,
      input logic e_busy, input logic [8:0] e_bia);
      vecs[nrow] = '{st, hd, rs, lw, pi, bia, e_iss, e_xb,
                     e_col, e_last, e_done, e_busy, e_bia};
      nrow++;
   endfunction

   // x3 line of 6 pixels: holds inserted before given issues,
   // optional ignored start pulse on the 3rd issue
   function automatic void add_line(input logic [8:0] bia,
      input int h2, input int h5, input logic ign);
      logic [8:0]       xs [6];
      logic [COL_W-1:0] cs [6];
      int nh;
      xs = '{9'd0, 9'd85, 9'd170, 9'd255, 9'd84, 9'd169};
      cs = '{12'd0, 12'd0, 12'd0, 12'd0, 12'd1, 12'd1};
      add_row(1, 0, 1, 12'd6, 9'd85, bia, 0, prev_xb, prev_col,
              0, 0, 0, prev_bia);
      for (int i = 0; i < 6; i++) begin
         nh = (i == 2) ? h2 : (i == 5) ? h5 : 0;
         for (int h = 0; h < nh; h++)
            add_row(0, 1, 1, 12'd6, 9'd85, bia, 0, xs[i], cs[i],
                    0, 0, 1, bia);
         if (ign && i == 2)
            add_row(1, 0, 1, 12'd3, 9'd128, 9'd77, 1, xs[i], cs[i],
                    0, 0, 1, bia);
         else
            add_row(0, 0, 1, 12'd6, 9'd85, bia, 1, xs[i], cs[i],
                    i == 5, 0, 1, bia);
      end
      for (int d = 0; d < LAT; d++)
         add_row(0, 0, 1, 12'd6, 9'd85, bia, 0, 9'd254, 12'd1,
                 0, 0, 1, bia);
      add_row(0, 0, 1, 12'd6, 9'd85, bia, 0, 9'd254, 12'd1,
              0, 1, 0, bia);
      add_row(0, 0, 1, 12'd6, 9'd85, bia, 0, 9'd254, 12'd1,
              0, 0, 0, bia);
      prev_xb  = 9'd254;
      prev_col = 12'd1;
      prev_bia = bia;
   endfunction

   task automatic chk(input string nm, input int r,
                      input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s row %0d: got %0d expected %0d",
                  nm, r, act, exp);
      end
   endtask

   initial begin
      logic             ew, el;
      logic [COL_W-1:0] ec;

      add_row(0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      add_row(0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      add_line(9'h1C0, 0, 0, 0);
      add_line(9'h1C0, 3, 1, 0);
      add_row(1, 0, 1, 12'd0, 9'd85, 9'd5, 0, prev_xb, prev_col,
              0, 0, 0, prev_bia);
      add_row(0, 0, 1, 12'd0, 9'd85, 9'd5, 0, 9'd0, 12'd0,
              0, 1, 0, 9'd5);
      add_row(0, 0, 1, 12'd0, 9'd85, 9'd5, 0, 9'd0, 12'd0,
              0, 0, 0, 9'd5);
      add_row(1, 0, 1, 12'd6, 9'd85, 9'h100, 0, 9'd0, 12'd0,
              0, 0, 0, 9'd5);
      add_row(0, 0, 1, 12'd6, 9'd85, 9'h100, 1, 9'd0, 12'd0,
              0, 0, 1, 9'h100);
      add_row(0, 0, 1, 12'd6, 9'd85, 9'h100, 1, 9'd85, 12'd0,
              0, 0, 1, 9'h100);
      add_row(0, 0, 1, 12'd6, 9'd85, 9'h100, 1, 9'd170, 12'd0,
              0, 0, 1, 9'h100);
      add_row(0, 1, 0, 12'd6, 9'd85, 9'h100, 0, 9'd255, 12'd0,
              0, 0, 1, 9'h100);
      for (int i = 0; i < 9; i++)
         add_row(0, 0, 1, 12'd6, 9'd85, 9'h100, 0, 9'd0, 12'd0,
                 0, 0, 0, 9'd0);
      prev_xb  = 9'd0;
      prev_col = '0;
      prev_bia = 9'd0;
      add_line(9'h0AA, 0, 0, 0);
      add_line(9'h033, 0, 0, 1);

      rst_n = 1'b0;
      start = 1'b0;
      hold  = 1'b0;
      line_width_out = '0;
      phase_inc = '0;
      bi_a_cfg  = '0;
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      @(negedge clk);

      for (int k = 0; k < nrow; k++) begin
         @(posedge clk);
         #1;
         start = vecs[k].st;
         hold  = vecs[k].hd;
         rst_n = vecs[k].rs;
         line_width_out = vecs[k].lw;
         phase_inc = vecs[k].pi;
         bi_a_cfg  = vecs[k].bia;
         #2;
         ew = (k >= LAT) ? h_iss[k-LAT]  : 1'b0;
         el = (k >= LAT) ? h_last[k-LAT] : 1'b0;
         ec = (k >= LAT) ? h_col[k-LAT]  : '0;
         chk("iss_valid", k, 32'(iss_valid), 32'(vecs[k].e_iss));
         chk("xBlend",    k, 32'(xBlend),    32'(vecs[k].e_xb));
         chk("src_col",   k, 32'(src_col),   32'(vecs[k].e_col));
         chk("done",      k, 32'(done),      32'(vecs[k].e_done));
         chk("busy",      k, 32'(busy),      32'(vecs[k].e_busy));
         chk("bi_a",      k, 32'(bi_a),      32'(vecs[k].e_bia));
         chk("w_valid",   k, 32'(w_valid),   32'(ew));
         chk("w_last",    k, 32'(w_last),    32'(el));
         chk("w_src_col", k, 32'(w_src_col), 32'(ec));
         chk("coeffOne",  k, 32'(coeffOne),  32'd256);
         chk("coeffHalf", k, 32'(coeffHalf), 32'd128);
         h_iss[k]  = vecs[k].e_iss;
         h_last[k] = vecs[k].e_last;
         h_col[k]  = vecs[k].e_col;
         if (!vecs[k].rs)
            for (int j = 0; j <= k; j++) begin
               h_iss[j]  = 1'b0;
               h_last[j] = 1'b0;
               h_col[j]  = '0;
            end
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
